// File: rtl/unit_buffer.sv
// Purpose : show-ahead FIFO holding matrix-unit result words and replaying them in order to the
//           matrix/buffer output multiplexer; also drives that multiplexer's select line.
// Latency : a word written in cycle N is visible on rd_data with rd_valid/selector high in cycle N+1.
// Backpressure: wr_ready = !full from registered count only, so a same-cycle read never opens a full buffer.
// Ports   : clk, rst_n (async active-low), flush (sync clear);
//           wr_valid/wr_ready/wr_data (matrix side); rd_valid/rd_ready/rd_data (mux side);
//           selector (1 = buffer path), count, full, empty, err_ovf (sticky write-while-full).
module unit_buffer #(
  parameter int WIDTH = 1024,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             selector,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             err_ovf
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             err_q, err_d;
  logic             wr_en, rd_en;

  // All flags come from the registered count; no input reaches them combinationally.
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign wr_ready = !full;
  assign rd_valid = !empty;
  assign selector = !empty;
  assign count    = count_q;
  assign err_ovf  = err_q;

  // Show-ahead head word, forced to zero while nothing is held.
  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];

  // flush wins over any same-cycle transfer.
  assign wr_en = wr_valid && !full && !flush;
  assign rd_en = rd_ready && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      err_d    = 1'b0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
      if (wr_valid && full) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_unit_buffer.sv
// Purpose : randomized and directed check of unit_buffer against a queue-based reference model.
// Latency : outputs are compared at each falling edge; the model advances on each rising edge.
// Backpressure: model rejects writes when it already holds DEPTH words, regardless of a same-cycle read.
module tb_unit_buffer;
  localparam int WIDTH = 1024;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             selector;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             err_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: ordered list of held words plus the sticky overflow flag.
  logic [WIDTH-1:0] mq[$];
  bit               err_m = 1'b0;

  unit_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .selector(selector), .count(count), .full(full), .empty(empty),
    .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got(lo128)=%h want(lo128)=%h", tag, $time, obs[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] w;
    for (int i = 0; i < WIDTH/32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic check_all();
    int n = mq.size();
    check("count",    count,    n);
    check("full",     full,     n == DEPTH);
    check("empty",    empty,    n == 0);
    check("selector", selector, n != 0);
    check("rd_valid", rd_valid, n != 0);
    check("wr_ready", wr_ready, n != DEPTH);
    check("err_ovf",  err_ovf,  err_m);
    check("rd_data",  rd_data,  (n != 0) ? mq[0] : '0);
  endtask

  task automatic model_step(input bit wv, input logic [WIDTH-1:0] wd, input bit rr, input bit fl);
    int n;
    if (!rst_n) begin
      mq.delete();
      err_m = 1'b0;
      return;
    end
    if (fl) begin
      mq.delete();
      err_m = 1'b0;
      return;
    end
    n = mq.size();
    if (wv && n == DEPTH) err_m = 1'b1;
    if (rr && n > 0) void'(mq.pop_front());
    if (wv && n < DEPTH) mq.push_back(wd);
  endtask

  // One clock: apply inputs, compare at the falling edge, advance the model at the rising edge.
  task automatic cycle(input bit wv, input logic [WIDTH-1:0] wd, input bit rr, input bit fl);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step(wv, wd, rr, fl);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] w;

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) cycle($urandom_range(0, 1), rand_word(), $urandom_range(0, 1), $urandom_range(0, 1));
    rst_n = 1'b1;
    #1;

    // Ordering: three writes with no reads, then drain.
    for (int i = 0; i < 3; i++) cycle(1, rand_word(), 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, rand_word(), 1, 0);

    // Fill, overflow attempt, drain.
    for (int i = 0; i < 4; i++) cycle(1, rand_word(), 0, 0);
    check("cnt_full_const", count, 4);
    cycle(1, rand_word(), 1, 0);          // full: write ignored, read happens
    check("ovf_set", err_ovf, 1);
    for (int i = 0; i < 5; i++) cycle(0, rand_word(), 1, 0);

    // Flush with count=3 and overflow flagged, alongside a write.
    for (int i = 0; i < 4; i++) cycle(1, rand_word(), 0, 0);
    cycle(1, rand_word(), 0, 0);          // overflow
    cycle(0, rand_word(), 1, 0);          // count 4 -> 3
    check("pre_flush_cnt", count, 3);
    cycle(1, rand_word(), 0, 1);
    check("post_flush_cnt", count, 0);
    check("post_flush_err", err_ovf, 0);

    // Concurrent read/write at count=2 for 10 cycles.
    for (int i = 0; i < 2; i++) cycle(1, rand_word(), 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, rand_word(), 1, 0);
    check("steady_cnt", count, 2);

    // Asynchronous reset between edges with words held.
    rst_n = 1'b0;
    #1;
    mq.delete();
    err_m = 1'b0;
    check_all();
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) cycle(1, rand_word(), 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, rand_word(), 1, 0);

    // Random traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      w = rand_word();
      cycle($urandom_range(0, 2) != 0, w, $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
